sort_stream_adapter: RTL and testbench
======================================

Name: sort_stream_adapter

Overview:
- Streaming front/back end for the team's packed-array byte sorter.
- Collects N bytes from a valid/ready input stream and packs them into the sorter's data vector.
- Pulses the sorter's start, waits for done, captures the sorted vector and streams the bytes back out in ascending order over a valid/ready output with a last marker.
- Drives the sorter's start/data_in side and consumes its done/data_out side; the sorter itself is instantiated beside it, not inside it.

Parameters:
- N, 4, element count; must match the sorter's N; 2..15.
- TIMEOUT, 64, max cycles spent in WAIT before abort; >= 2.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input byte valid
- in_ready  out  1  adapter accepts input byte
- in_data  in  8  input byte
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts output byte
- out_data  out  8  output byte
- out_last  out  1  marks the Nth output byte
- sort_start  out  1  to sorter start, one-cycle pulse
- sort_data  out  N*8  to sorter data_in; element k at [k*8 +: 8]
- sort_done  in  1  from sorter done
- sort_result  in  N*8  from sorter data_out
- busy  out  1  high in any state except LOAD
- timeout_err  out  1  sticky abort flag

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - state=LOAD; element count and output index 0.
  - sort_start=0, sort_data=0, out_valid=0, out_last=0, out_data=0.
  - timeout_err=0, busy=0; in_ready=1 from the first cycle after reset.
- Reset mid-operation: any state returns to LOAD and discards partial input and the captured result. No start pulse is emitted in the reset cycle or the cycle after.
- Handshake: a transfer occurs on a cycle with valid&&ready. out_valid, out_data and out_last hold stable until accepted. in_ready and out_valid are decoded from registered state.
- Sorter contract:
  - done falls in the cycle after start is sampled.
  - done may be stale-high before that; it is ignored in KICK.
  - data_out is valid from the second consecutive cycle done is high.
- LOAD:
  - in_ready=1. Input byte k (0-based arrival order) is written to sort_data[k*8 +: 8] on transfer.
  - On the Nth transfer, go to KICK.
  - sort_data is registered and held constant until the next LOAD.
- KICK: sort_start=1 for exactly one cycle, in_ready=0. Go to WAIT.
- WAIT:
  - Cycle counter is cleared on entry.
  - If sort_done=1, go to SETTLE.
  - Else if counter==TIMEOUT-1: set timeout_err=1, go to LOAD with count cleared and no output produced.
  - Counter width is clog2(TIMEOUT)+1.
- SETTLE: one cycle. At its closing edge, capture sort_result into the output buffer and go to DRAIN.
- DRAIN:
  - out_valid=1; out_data=buffer[idx], starting at idx=0 (smallest).
  - out_last=1 when idx==N-1.
  - Each transfer increments idx. Transfer at idx==N-1 clears idx and goes to LOAD.
- Input and output phases do not overlap; in_ready=0 outside LOAD.
- Latency:
  - sort_start is high in the cycle after the Nth input transfer.
  - First out_valid is 2 cycles after sort_done is first sampled high in WAIT.
- Back-to-back: the next frame can begin the cycle after the final out_last transfer.
- timeout_err is cleared only by rst; it does not block further frames.
- Sorted order is ascending unsigned. Duplicates are passed through unchanged. No arithmetic beyond counters; all counters saturate-free and bounded by N or TIMEOUT.

Test Plan:
- Basic frame:
  - Stimulus: input 0x30,0x10,0x40,0x20 at full rate; reference sorter attached.
  - Required: sort_data=0x20401030; one-cycle sort_start; outputs 0x10,0x20,0x30,0x40; out_last only on 0x40; then in_ready=1.
- Output backpressure:
  - Stimulus: same frame, out_ready toggled 1,0,0,1,0,1,1.
  - Required: out_data holds while out_valid&&!out_ready; no byte lost or repeated; exactly 4 transfers.
- Duplicates and input gaps:
  - Stimulus: input 0xFF,0x00,0xFF,0x00 with in_valid low on alternate cycles.
  - Required: 0x00,0x00,0xFF,0xFF.
- Timeout:
  - Stimulus: sort_done tied 0 after one frame is loaded.
  - Required: timeout_err rises exactly 64 cycles after WAIT entry; state returns to LOAD; out_valid never asserted.
- Stale done:
  - Stimulus: sort_done held 1 through KICK, then 0 for 10 cycles, then 1.
  - Required: SETTLE is entered only after the later rise; output reflects sort_result sampled at the SETTLE edge.
- Reset mid-operation:
  - Stimulus: assert rst after the 2nd output byte, then send a new frame 0x05,0x04,0x03,0x02.
  - Required: all outputs at reset values the cycle after rst; new frame yields 0x02,0x03,0x04,0x05.

Source files
------------

// File: rtl/sort_stream_adapter.sv
// Streams N bytes into the external sorter, kicks it, then streams the sorted bytes back out.
// Latency: start 1 cycle after the Nth input; first output 2 cycles after done; out_* hold while !out_ready.
module sort_stream_adapter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_data,
  output logic           out_last,
  output logic           sort_start,
  output logic [N*8-1:0] sort_data,
  input  logic           sort_done,
  input  logic [N*8-1:0] sort_result,
  output logic           busy,
  output logic           timeout_err
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_LOAD, S_KICK, S_WAIT, S_SETTLE, S_DRAIN} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  wcnt_q, wcnt_d;
  logic [N*8-1:0] sort_data_q, sort_data_d;
  logic [N*8-1:0] res_q, res_d;
  logic           timeout_err_q, timeout_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LOAD;
      cnt_q         <= '0;
      idx_q         <= '0;
      wcnt_q        <= '0;
      sort_data_q   <= '0;
      res_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      wcnt_q        <= wcnt_d;
      sort_data_q   <= sort_data_d;
      res_q         <= res_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    wcnt_d        = wcnt_q;
    sort_data_d   = sort_data_q;
    res_d         = res_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          for (int k = 0; k < N; k++) begin
            if (cnt_q == IW'(k)) sort_data_d[k*8 +: 8] = in_data;
          end
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = S_KICK;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      // A done still high from the previous frame is ignored here.
      S_KICK: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sort_done) begin
          state_d = S_SETTLE;
        end else if (wcnt_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_LOAD;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      // Sorter output is only trustworthy on the second consecutive done cycle.
      S_SETTLE: begin
        res_d   = sort_result;
        idx_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    out_data = '0;
    if (state_q == S_DRAIN) begin
      for (int k = 0; k < N; k++) begin
        if (idx_q == IW'(k)) out_data = res_q[k*8 +: 8];
      end
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign out_valid   = (state_q == S_DRAIN);
  assign out_last    = (state_q == S_DRAIN) && (idx_q == LAST_IDX);
  assign sort_start  = (state_q == S_KICK);
  assign busy        = (state_q != S_LOAD);
  assign sort_data   = sort_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Bench for sort_stream_adapter with a behavioural sorter beside the DUT.
module tb_sort_stream_adapter;

  localparam int N       = 4;
  localparam int TIMEOUT = 64;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic [7:0]     in_data   = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [7:0]     out_data;
  logic           out_last;
  logic           sort_start;
  logic [N*8-1:0] sort_data;
  logic           sort_done;
  logic [N*8-1:0] sort_result;
  logic           busy;
  logic           timeout_err;

  bit             sorter_en  = 1'b1;
  logic           man_done   = 1'b0;
  logic [N*8-1:0] man_result = '0;
  logic           mdl_done   = 1'b1;
  logic [N*8-1:0] mdl_res    = '0;
  logic [N*8-1:0] mdl_buf    = '0;
  int             mdl_cnt    = 0;
  int             mdl_lat    = 2;

  int             total  = 0;
  int             passed = 0;
  int             fails  = 0;
  logic [N*8-1:0] frame_vec;
  logic [N*8-1:0] exp_vec;
  logic [6:0]     bp_pat = 7'b1101001;

  sort_stream_adapter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sort_start(sort_start), .sort_data(sort_data),
    .sort_done(sort_done), .sort_result(sort_result),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign sort_done   = sorter_en ? mdl_done : man_done;
  assign sort_result = sorter_en ? mdl_res  : man_result;

  function automatic logic [N*8-1:0] sorted_vec(input logic [N*8-1:0] v);
    logic [7:0] a [N];
    logic [7:0] t;
    logic [N*8-1:0] r;
    for (int k = 0; k < N; k++) a[k] = v[k*8 +: 8];
    for (int i = 0; i < N - 1; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int k = 0; k < N; k++) r[k*8 +: 8] = a[k];
    return r;
  endfunction

  // Reference sorter: done drops after start, rises mdl_lat cycles later with the sorted vector.
  always @(posedge clk) begin
    if (sort_start) begin
      mdl_done <= 1'b0;
      mdl_cnt  <= mdl_lat;
      mdl_buf  <= sort_data;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        mdl_done <= 1'b1;
        mdl_res  <= sorted_vec(mdl_buf);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    frame_vec = {b3, b2, b1, b0};
  endtask

  task automatic set_rand();
    for (int k = 0; k < N; k++) frame_vec[k*8 +: 8] = 8'($urandom);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sort_start", sort_start, 0);
    check("rst_sort_data", sort_data, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
  endtask

  // gap_mode: 0 full rate, 1 alternate cycles idle, 2 random idle cycles
  task automatic load(input int gap_mode);
    int k = 0;
    int t = 0;
    bit xfer;
    exp_vec = sorted_vec(frame_vec);
    while (k < N && t < 200) begin
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((t % 2) == 1);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = frame_vec[k*8 +: 8];
      xfer = in_valid && in_ready;
      step();
      t++;
      if (xfer) k++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    check("load_count", k, N);
    check("kick_start", sort_start, 1);
    check("kick_in_ready", in_ready, 0);
    check("kick_sort_data", sort_data, frame_vec);
    step();
    check("start_one_cycle", sort_start, 0);
    check("wait_busy", busy, 1);
  endtask

  // ready_mode: 0 always ready, 1 fixed 1,0,0,1,0,1,1 pattern, 2 random
  task automatic drain(input int ready_mode, input int n_out, input bit chk_lat);
    int got = 0;
    int t = 0;
    int t_done = -1;
    int t_v = -1;
    int pi = 0;
    bit hold = 1'b0;
    bit xfer;
    logic [7:0] prev_d = '0;
    while (got < n_out && t < 400) begin
      if (sort_done === 1'b1 && t_done < 0) t_done = t;
      if (out_valid === 1'b1 && t_v < 0) t_v = t;
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_d);
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = bp_pat[pi % 7];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      xfer = out_valid && out_ready;
      if (out_valid) pi++;
      if (xfer) begin
        check("out_data", out_data, exp_vec[got*8 +: 8]);
        check("out_last", out_last, (got == N - 1));
        got++;
      end
      hold   = out_valid && !out_ready;
      prev_d = out_data;
      step();
      t++;
    end
    out_ready = 1'b0;
    check("out_count", got, n_out);
    if (chk_lat) check("first_valid_latency", t_v - t_done, 2);
  endtask

  task automatic check_idle();
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int t;
    bit seen_valid;
    logic [N*8-1:0] g;

    rst = 1'b1;
    repeat (2) step();
    check_reset_vals();
    rst = 1'b0;
    step();
    check("post_rst_no_start", sort_start, 0);
    check("post_rst_in_ready", in_ready, 1);

    // basic frame at full rate
    mdl_lat = 3;
    set4(8'h30, 8'h10, 8'h40, 8'h20);
    load(0);
    check("basic_packed", sort_data, 32'h20401030);
    drain(0, N, 1);
    check_idle();

    // output backpressure, back-to-back with the previous frame
    mdl_lat = 1;
    load(0);
    drain(1, N, 1);
    check_idle();

    // duplicates with idle input cycles
    mdl_lat = 4;
    set4(8'hFF, 8'h00, 8'hFF, 8'h00);
    load(1);
    drain(0, N, 1);
    check_idle();

    // random frames, random gaps and random backpressure
    for (int f = 0; f < 6; f++) begin
      mdl_lat = $urandom_range(1, 8);
      set_rand();
      load(2);
      drain(2, N, 1);
      check_idle();
    end

    // sorter never answers
    check("pre_timeout_flag", timeout_err, 0);
    sorter_en = 1'b0;
    man_done  = 1'b0;
    set_rand();
    load(0);
    t = 0;
    seen_valid = 1'b0;
    while (timeout_err !== 1'b1 && t < 200) begin
      if (out_valid === 1'b1) seen_valid = 1'b1;
      step();
      t++;
    end
    check("timeout_cycles", t, TIMEOUT);
    check("timeout_no_output", seen_valid, 0);
    check_idle();

    // stale done through KICK, real done 10 cycles later; result only good at SETTLE
    man_done = 1'b1;
    set_rand();
    load(0);
    man_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stale_no_output", out_valid, 0);
    end
    set_rand();
    exp_vec    = sorted_vec(frame_vec);
    g          = {$urandom};
    man_done   = 1'b1;
    man_result = g;
    step();
    check("settle_no_output", out_valid, 0);
    man_result = exp_vec;
    step();
    man_result = ~exp_vec;
    check("stale_drain_valid", out_valid, 1);
    drain(0, N, 0);
    check_idle();
    check("timeout_sticky", timeout_err, 1);
    man_done  = 1'b0;
    sorter_en = 1'b1;

    // reset after the 2nd output byte
    mdl_lat = 2;
    set_rand();
    load(0);
    drain(0, 2, 0);
    rst = 1'b1;
    step();
    check_reset_vals();
    rst = 1'b0;
    step();
    check("post_rst2_no_start", sort_start, 0);
    set4(8'h05, 8'h04, 8'h03, 8'h02);
    load(0);
    drain(0, N, 1);
    check_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
